// File: rtl/ll_empty_ptr_storage_pkg.sv
// Shared linked-list types and sizing for the data/head tables and their free-pointer pool.
package linked_list;

  localparam int unsigned TABLE_ADDR_WIDTH = 10;
  localparam int unsigned TABLE_SIZE       = 2 ** TABLE_ADDR_WIDTH;

  typedef enum logic [1:0] {
    S_INIT,
    S_PREFETCH,
    S_RUN
  } ll_eps_state_t;

endpackage

// File: rtl/ll_empty_ptr_storage_sdp_ram.sv
// Simple dual-port RAM: one write port, one read port with a 1-cycle registered read.
module ll_sdp_ram #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Read-during-write to the same address returns the old contents.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/ll_empty_ptr_storage.sv
// Free-pointer pool for the linked-list data table: show-ahead circular FIFO
// of unused entry addresses, filled with every address after reset.
module ll_empty_ptr_storage
  import linked_list::*;
#(
  parameter int unsigned A_WIDTH   = TABLE_ADDR_WIDTH,
  parameter int unsigned CNT_WIDTH = A_WIDTH + 1
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  output logic                 init_done_o,
  input  logic [A_WIDTH-1:0]   add_empty_ptr_i,
  input  logic                 add_empty_ptr_en_i,
  output logic [A_WIDTH-1:0]   next_empty_ptr_o,
  output logic                 next_empty_ptr_val_o,
  input  logic                 next_empty_ptr_rd_ack_i,
  output logic [CNT_WIDTH-1:0] empty_cnt_o,
  output logic                 overflow_o,
  output logic                 underflow_o
);

  localparam int unsigned           DEPTH    = 1 << A_WIDTH;
  localparam logic [CNT_WIDTH-1:0]  CNT_FULL = CNT_WIDTH'(DEPTH);
  localparam logic [A_WIDTH-1:0]    PTR_LAST = A_WIDTH'(DEPTH - 1);

  ll_eps_state_t        state_q;
  logic [A_WIDTH-1:0]   wr_ptr_q;
  logic [A_WIDTH-1:0]   rd_ptr_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic                 init_done_q;
  logic                 val_q;
  logic                 ovf_q;
  logic                 udf_q;
  logic                 byp_sel_q;
  logic [A_WIDTH-1:0]   byp_ptr_q;

  logic                 run;
  logic                 ack_v;
  logic                 add_ok;
  logic                 pop_empties;
  logic [CNT_WIDTH-1:0] cnt_d;
  logic                 ram_we;
  logic [A_WIDTH-1:0]   ram_wdata;
  logic [A_WIDTH-1:0]   ram_raddr;
  logic [A_WIDTH-1:0]   ram_rdata;

  // Qualified strobes; a full pool still accepts a return paired with a pop.
  always_comb begin
    run         = (state_q == S_RUN);
    ack_v       = run && next_empty_ptr_rd_ack_i && val_q;
    add_ok      = run && add_empty_ptr_en_i && ((cnt_q != CNT_FULL) || ack_v);
    pop_empties = (cnt_q == CNT_WIDTH'(ack_v));
    cnt_d       = cnt_q + CNT_WIDTH'(add_ok) - CNT_WIDTH'(ack_v);
    ram_we      = (state_q == S_INIT) || add_ok;
    ram_wdata   = (state_q == S_INIT) ? wr_ptr_q : add_empty_ptr_i;
    ram_raddr   = rd_ptr_q + A_WIDTH'(ack_v);
  end

  ll_sdp_ram #(
    .DATA_W (A_WIDTH),
    .ADDR_W (A_WIDTH)
  ) u_ram (
    .clk_i   (clk_i),
    .we_i    (ram_we),
    .waddr_i (wr_ptr_q),
    .wdata_i (ram_wdata),
    .raddr_i (ram_raddr),
    .rdata_o (ram_rdata)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= S_INIT;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      init_done_q <= 1'b0;
      val_q       <= 1'b0;
      ovf_q       <= 1'b0;
      udf_q       <= 1'b0;
      byp_sel_q   <= 1'b0;
      byp_ptr_q   <= '0;
    end else begin
      case (state_q)
        S_INIT: begin
          wr_ptr_q <= wr_ptr_q + A_WIDTH'(1);
          if (wr_ptr_q == PTR_LAST) begin
            cnt_q   <= CNT_FULL;
            state_q <= S_PREFETCH;
          end
        end
        S_PREFETCH: begin
          state_q     <= S_RUN;
          init_done_q <= 1'b1;
          val_q       <= (cnt_q != '0);
          byp_sel_q   <= 1'b0;
        end
        S_RUN: begin
          if (add_ok) begin
            wr_ptr_q  <= wr_ptr_q + A_WIDTH'(1);
            byp_ptr_q <= add_empty_ptr_i;
          end
          if (ack_v) begin
            rd_ptr_q <= rd_ptr_q + A_WIDTH'(1);
          end
          cnt_q <= cnt_d;
          val_q <= (cnt_d != '0);
          // RAM would return stale data when the new head is written this cycle.
          byp_sel_q <= add_ok && pop_empties;
          if (add_empty_ptr_en_i && !add_ok) begin
            ovf_q <= 1'b1;
          end
          if (next_empty_ptr_rd_ack_i && !val_q) begin
            udf_q <= 1'b1;
          end
        end
        default: state_q <= S_INIT;
      endcase
    end
  end

  assign init_done_o          = init_done_q;
  assign next_empty_ptr_val_o = val_q;
  assign next_empty_ptr_o     = !val_q ? '0 : (byp_sel_q ? byp_ptr_q : ram_rdata);
  assign empty_cnt_o          = cnt_q;
  assign overflow_o           = ovf_q;
  assign underflow_o          = udf_q;

endmodule
